// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the neuron datapath controllers.
package nn_pkg;
  localparam int CFG_ID_W = 32;
  typedef enum logic {IDLE, RUN} weight_seq_state_t;
endpackage

// File: rtl/weight_seq_ctrl.sv
// weight_seq_ctrl: weight-memory loader and per-sample read sequencer for one neuron.
module weight_seq_ctrl
  import nn_pkg::*;
#(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int layerNo      = 0,
  parameter int neuronNo     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CFG_ID_W-1:0]     cfg_layer,
  input  logic [CFG_ID_W-1:0]     cfg_neuron,
  input  logic [dataWidth-1:0]    cfg_data,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    wm_wr_en,
  output logic [addressWidth-1:0] wm_wr_addr,
  output logic [dataWidth-1:0]    wm_wr_data,
  output logic                    wm_rd_en,
  output logic [addressWidth-1:0] wm_rd_addr,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic                    mac_last,
  output logic                    busy
);
  localparam logic [addressWidth-1:0] LAST  = addressWidth'(numWeight - 1);
  localparam logic [addressWidth-1:0] ONE   = addressWidth'(1);
  localparam logic                    MULTI = numWeight > 1;
  weight_seq_state_t       state_q, state_d;
  logic [addressWidth-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                    mac_valid_q, mac_last_q, rd_last, match;
  logic [dataWidth-1:0]    mac_x_q;
  always_comb begin
    cfg_ready  = state_q == IDLE && !in_valid && !mac_valid_q;
    match      = cfg_layer == CFG_ID_W'(layerNo) && cfg_neuron == CFG_ID_W'(neuronNo);
    wm_wr_en   = cfg_valid && cfg_ready && match;
    wm_wr_addr = wr_cnt_q;
    wm_wr_data = cfg_data;
    wm_rd_en   = in_valid;
    wm_rd_addr = rd_cnt_q;
    rd_last    = rd_cnt_q == LAST;
    wr_cnt_d   = wm_wr_en ? (wr_cnt_q == LAST ? '0 : wr_cnt_q + ONE) : wr_cnt_q;
    rd_cnt_d   = in_valid ? (rd_last ? '0 : rd_cnt_q + ONE) : rd_cnt_q;
    state_d    = !in_valid ? state_q :
                 rd_last ? IDLE :
                 (state_q == IDLE && rd_cnt_q == '0 && MULTI) ? RUN : state_q;
    mac_valid  = mac_valid_q;
    mac_x      = mac_x_q;
    mac_last   = mac_last_q;
    busy       = state_q == RUN || mac_valid_q;
  end
  // Non-matching beats are consumed without touching wr_cnt; inference always wins cfg_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_x_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      mac_valid_q <= in_valid;
      mac_last_q  <= in_valid && rd_last;
      mac_x_q     <= in_valid ? in_data : mac_x_q;
    end
  end
endmodule

// File: tb/tb_weight_seq_ctrl.sv
// tb_weight_seq_ctrl: table vectors, corner sequences and random traffic against a pass-counting model.
module tb_weight_seq_ctrl;
  localparam int N = 3;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_valid = 1'b0, in_valid = 1'b0;
  logic [31:0] cfg_layer = '0, cfg_neuron = '0;
  logic [15:0] cfg_data = '0, in_data = '0;
  logic        cfg_ready, wm_wr_en, wm_rd_en, mac_valid, mac_last, busy;
  logic [9:0]  wm_wr_addr, wm_rd_addr;
  logic [15:0] wm_wr_data, mac_x, rd_data;
  logic [15:0] mem [0:3];
  int vectors = 0, miscompares = 0;
  int wr_i, rd_i, m_pv, m_pl, m_x, m_w;
  int wmem [0:N-1];
  logic a_ready, a_wren, a_mv, a_ml, a_busy;
  logic [9:0]  a_wraddr, a_rdaddr;
  logic [15:0] a_mx;

  weight_seq_ctrl #(.numWeight(N), .addressWidth(10), .dataWidth(16), .layerNo(0), .neuronNo(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_neuron(cfg_neuron), .cfg_data(cfg_data), .in_valid(in_valid), .in_data(in_data),
    .wm_wr_en(wm_wr_en), .wm_wr_addr(wm_wr_addr), .wm_wr_data(wm_wr_data), .wm_rd_en(wm_rd_en),
    .wm_rd_addr(wm_rd_addr), .mac_valid(mac_valid), .mac_x(mac_x), .mac_last(mac_last), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wm_wr_en) mem[wm_wr_addr[1:0]] <= wm_wr_data;
    if (wm_rd_en) rd_data <= mem[wm_rd_addr[1:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_i = 0; rd_i = 0; m_pv = 0; m_pl = 0; m_x = 0;
  endtask

  // A pass is in progress whenever the number of samples taken is not a multiple of N.
  task automatic step(input logic cv, input logic [31:0] cl, input logic [31:0] cn, input logic [15:0] cd,
                      input logic iv, input logic [15:0] id);
    logic e_ready, e_wr;
    @(negedge clk);
    cfg_valid = cv; cfg_layer = cl; cfg_neuron = cn; cfg_data = cd; in_valid = iv; in_data = id;
    #4;
    a_ready = cfg_ready; a_wren = wm_wr_en; a_wraddr = wm_wr_addr; a_rdaddr = wm_rd_addr;
    a_mv = mac_valid; a_mx = mac_x; a_ml = mac_last; a_busy = busy;
    e_ready = rd_i == 0 && !iv && m_pv == 0;
    e_wr = cv && e_ready && cl == 0 && cn == 0;
    chk("cfg_ready", cfg_ready, e_ready);
    chk("wr_en", wm_wr_en, e_wr);
    if (e_wr) begin
      chk("wr_addr", wm_wr_addr, wr_i);
      chk("wr_data", wm_wr_data, cd);
    end
    chk("rd_en", wm_rd_en, iv);
    if (iv) chk("rd_addr", wm_rd_addr, rd_i);
    chk("mac_valid", mac_valid, m_pv);
    chk("mac_x", mac_x, m_x);
    chk("mac_last", mac_last, m_pl);
    chk("busy", busy, rd_i != 0 || m_pv != 0);
    if (m_pv != 0) chk("rd_data", rd_data, m_w);
    @(posedge clk);
    if (e_wr) begin
      wmem[wr_i] = cd;
      wr_i = (wr_i + 1) % N;
    end
    m_pv = iv; m_pl = iv && rd_i == N - 1;
    if (iv) begin
      m_x = id; m_w = wmem[rd_i];
      rd_i = (rd_i + 1) % N;
    end
  endtask

  typedef struct {
    logic cv; logic [31:0] cn; logic [15:0] cd; logic iv; logic [15:0] id;
    logic ready; logic wren; logic [9:0] wraddr; logic [9:0] rdaddr;
    logic mv; logic [15:0] mx; logic ml; logic busy;
  } vec_t;
  vec_t tbl [0:17];

  initial begin
    int lasts;
    model_reset();
    for (int i = 0; i < N; i++) wmem[i] = 0;
    tbl[0]  = '{1, 0, 16'h11, 0, 0,  1, 1, 0, 0, 0, 0,  0, 0};
    tbl[1]  = '{1, 0, 16'h22, 0, 0,  1, 1, 1, 0, 0, 0,  0, 0};
    tbl[2]  = '{1, 0, 16'h33, 0, 0,  1, 1, 2, 0, 0, 0,  0, 0};
    tbl[3]  = '{1, 0, 16'h44, 0, 0,  1, 1, 0, 0, 0, 0,  0, 0};
    tbl[4]  = '{1, 1, 16'h55, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0};
    tbl[5]  = '{1, 0, 16'h66, 0, 0,  1, 1, 1, 0, 0, 0,  0, 0};
    tbl[6]  = '{0, 0, 0,      1, 5,  0, 0, 0, 0, 0, 0,  0, 0};
    tbl[7]  = '{0, 0, 0,      1, 6,  0, 0, 0, 1, 1, 5,  0, 1};
    tbl[8]  = '{0, 0, 0,      1, 7,  0, 0, 0, 2, 1, 6,  0, 1};
    tbl[9]  = '{0, 0, 0,      0, 0,  0, 0, 0, 0, 1, 7,  1, 1};
    tbl[10] = '{0, 0, 0,      0, 0,  1, 0, 0, 0, 0, 7,  0, 0};
    tbl[11] = '{1, 0, 16'h77, 1, 8,  0, 0, 0, 0, 0, 7,  0, 0};
    tbl[12] = '{1, 0, 16'h77, 0, 0,  0, 0, 0, 0, 1, 8,  0, 1};
    tbl[13] = '{1, 0, 16'h77, 1, 9,  0, 0, 0, 1, 0, 8,  0, 1};
    tbl[14] = '{1, 0, 16'h77, 1, 10, 0, 0, 0, 2, 1, 9,  0, 1};
    tbl[15] = '{1, 0, 16'h77, 0, 0,  0, 0, 0, 0, 1, 10, 1, 1};
    tbl[16] = '{1, 0, 16'h77, 0, 0,  1, 1, 2, 0, 0, 10, 0, 0};
    tbl[17] = '{0, 0, 0,      0, 0,  1, 0, 0, 0, 0, 10, 0, 0};
    #1;
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].cv, 0, tbl[i].cn, tbl[i].cd, tbl[i].iv, tbl[i].id);
      chk($sformatf("t%0d_ready", i), a_ready, tbl[i].ready);
      chk($sformatf("t%0d_wren", i), a_wren, tbl[i].wren);
      if (tbl[i].wren) chk($sformatf("t%0d_wraddr", i), a_wraddr, tbl[i].wraddr);
      if (tbl[i].iv) chk($sformatf("t%0d_rdaddr", i), a_rdaddr, tbl[i].rdaddr);
      chk($sformatf("t%0d_mv", i), a_mv, tbl[i].mv);
      chk($sformatf("t%0d_mx", i), a_mx, tbl[i].mx);
      chk($sformatf("t%0d_ml", i), a_ml, tbl[i].ml);
      chk($sformatf("t%0d_busy", i), a_busy, tbl[i].busy);
    end
    // gap inside a pass, then back-to-back passes
    lasts = 0;
    step(0, 0, 0, 0, 1, 16'h101);
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, 16'hbad, 0, 0); lasts += a_ml; end
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 1, 16'h200 + 16'(i)); lasts += a_ml; end
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 0, 0, 0); lasts += a_ml; end
    chk("gap_last_pulses", lasts, 2);
    // reset after the second sample of a pass
    step(0, 0, 0, 0, 1, 16'h301);
    step(0, 0, 0, 0, 1, 16'h302);
    @(negedge clk);
    in_valid = 1'b0; cfg_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("rstmid_mac_valid", mac_valid, 0);
    chk("rstmid_mac_last", mac_last, 0);
    chk("rstmid_mac_x", mac_x, 0);
    chk("rstmid_busy", busy, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 16'h401);
    chk("rstmid_rd_addr", a_rdaddr, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 16'h501, 0, 0);
    chk("rstmid_wr_addr", a_wraddr, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           16'($urandom), $urandom_range(0, 2) == 0, 16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
